// File: rtl/cfpu_pipe.sv
// cfpu_pipe: pipelined complex ADD/MULT on floatType values with an optional running accumulator.
// Latency: STAGES cycles from input transfer to out_valid, one result per cycle. CFPU_CONJ_EN adds conj_b.
// Backpressure: valid/ready both sides; in_ready is combinational from out_ready through the slots.
package cfpu_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mantis;
    } floatType;

    typedef struct packed {
        floatType r;
        floatType i;
    } complex;

    typedef enum logic {ADD, MULT} FPU_opcode;

    function automatic floatType fp_neg(input floatType a);
        floatType res;
        res = a;
        res.sign = ~a.sign;
        return res;
    endfunction

    // Truncating multiply; exp==0 operands are treated as zero and zero results are +0.
    function automatic floatType fp_mul(input floatType a, input floatType b);
        floatType    res;
        logic [47:0] p;
        logic [9:0]  e;
        res = '0;
        if (a.exp != 8'd0 && b.exp != 8'd0) begin
            p = {1'b1, a.mantis} * {1'b1, b.mantis};
            e = {2'b00, a.exp} + {2'b00, b.exp} - 10'd127 + {9'd0, p[47]};
            if (e[9] || e == 10'd0) begin
                res = '0;
            end else if (e >= 10'd255) begin
                res = {a.sign ^ b.sign, 8'hff, 23'd0};
            end else begin
                res.sign   = a.sign ^ b.sign;
                res.exp    = e[7:0];
                res.mantis = p[47] ? p[46:24] : p[45:23];
            end
        end
        return res;
    endfunction

    function automatic floatType fp_add(input floatType a, input floatType b);
        floatType    res, big, sml;
        logic [24:0] mb, ms, s;
        logic [7:0]  d;
        logic [4:0]  lz;
        logic        found;
        res = '0;
        if (a.exp == 8'd0 && b.exp == 8'd0) begin
            res = '0;
        end else if (a.exp == 8'd0) begin
            res = b;
        end else if (b.exp == 8'd0) begin
            res = a;
        end else begin
            if ({a.exp, a.mantis} >= {b.exp, b.mantis}) begin
                big = a;
                sml = b;
            end else begin
                big = b;
                sml = a;
            end
            d  = big.exp - sml.exp;
            mb = {2'b01, big.mantis};
            ms = {2'b01, sml.mantis} >> d;
            if (big.sign == sml.sign) begin
                s = mb + ms;
                res.sign = big.sign;
                if (s[24]) begin
                    res.exp    = big.exp + 8'd1;
                    res.mantis = s[23:1];
                end else begin
                    res.exp    = big.exp;
                    res.mantis = s[22:0];
                end
            end else begin
                // Magnitude ordering above keeps the difference non-negative; renormalise.
                s = mb - ms;
                lz = '0;
                found = 1'b0;
                for (int i = 23; i >= 0; i--) begin
                    if (!found) begin
                        if (s[i]) found = 1'b1;
                        else      lz = lz + 5'd1;
                    end
                end
                if (!found || big.exp <= {3'd0, lz}) begin
                    res = '0;
                end else begin
                    s = s << lz;
                    res.sign   = big.sign;
                    res.exp    = big.exp - {3'd0, lz};
                    res.mantis = s[22:0];
                end
            end
        end
        return res;
    endfunction

    function automatic complex c_add(input complex a, input complex b);
        complex res;
        res.r = fp_add(a.r, b.r);
        res.i = fp_add(a.i, b.i);
        return res;
    endfunction

endpackage

module cfpu_pipe
    import cfpu_pkg::*;
#(
    parameter FPU_opcode OP     = ADD,
    parameter int        STAGES = 2,
    parameter int        ACCUM  = 0
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   in_valid,
    output logic   in_ready,
    input  complex A,
    input  complex B,
`ifdef CFPU_CONJ_EN
    input  logic   conj_b,
`endif
    input  logic   clr,
    output logic   out_valid,
    input  logic   out_ready,
    output complex result
);

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("cfpu_pipe: STAGES must be in 1..4");
    end
    if (OP == MULT && STAGES < 2) begin : g_bad_mult
        $error("cfpu_pipe: MULT needs STAGES >= 2");
    end

    // One slot word: four partial products after s1 of MULT, otherwise p0/p1 hold the complex value.
    typedef struct packed {
        floatType p0;
        floatType p1;
        floatType p2;
        floatType p3;
        logic     clr;
    } word_t;

    word_t             in_word;
    complex            b_eff;
    word_t             dat [1:STAGES];
    word_t             src [1:STAGES];
    word_t             nxt [1:STAGES];
    logic [STAGES:1]   v;
    logic [STAGES:1]   sv;
    logic [STAGES:1]   ld;
    complex            acc;
    complex            x_n;
    logic              xfer_n;

    always_comb begin
        b_eff = B;
`ifdef CFPU_CONJ_EN
        b_eff.i.sign = B.i.sign ^ conj_b;
`endif
        in_word.p0  = A.r;
        in_word.p1  = A.i;
        in_word.p2  = b_eff.r;
        in_word.p3  = b_eff.i;
        in_word.clr = clr && (ACCUM != 0);
    end

    always_comb begin
        src[1] = in_word;
        sv[1]  = in_valid;
        for (int k = 2; k <= STAGES; k++) begin
            src[k] = dat[k-1];
            sv[k]  = v[k-1];
        end
    end

    always_comb begin
        for (int k = 1; k <= STAGES; k++) begin
            nxt[k] = src[k];
            if (k == 1 && OP == MULT) begin
                nxt[k].p0 = fp_mul(src[k].p0, src[k].p2);
                nxt[k].p1 = fp_mul(src[k].p1, src[k].p3);
                nxt[k].p2 = fp_mul(src[k].p1, src[k].p2);
                nxt[k].p3 = fp_mul(src[k].p0, src[k].p3);
            end else if (k == 1) begin
                nxt[k].p0 = fp_add(src[k].p0, src[k].p2);
                nxt[k].p1 = fp_add(src[k].p1, src[k].p3);
                nxt[k].p2 = '0;
                nxt[k].p3 = '0;
            end else if (k == 2 && OP == MULT) begin
                nxt[k].p0 = fp_add(src[k].p0, fp_neg(src[k].p1));
                nxt[k].p1 = fp_add(src[k].p2, src[k].p3);
                nxt[k].p2 = '0;
                nxt[k].p3 = '0;
            end
        end
    end

    // A slot may load when it is empty or its content moves on this cycle.
    always_comb begin
        logic chain;
        chain = out_ready;
        ld    = '0;
        for (int k = STAGES; k >= 1; k--) begin
            chain = !v[k] || chain;
            ld[k] = chain;
        end
    end

    assign xfer_n   = ld[STAGES] && sv[STAGES];
    assign x_n      = {nxt[STAGES].p0, nxt[STAGES].p1};
    assign in_ready = ld[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v   <= '0;
            acc <= '0;
            for (int k = 1; k <= STAGES; k++) dat[k] <= '0;
        end else begin
            for (int k = 1; k <= STAGES; k++) begin
                if (ld[k]) begin
                    v[k] <= sv[k];
                    if (sv[k]) dat[k] <= nxt[k];
                end
            end
            if (ACCUM != 0 && xfer_n) begin
                acc <= nxt[STAGES].clr ? x_n : c_add(acc, x_n);
            end
        end
    end

    assign out_valid = v[STAGES];
    assign result    = (ACCUM != 0) ? acc : {dat[STAGES].p0, dat[STAGES].p1};

endmodule
